// File: rtl/cipher_stream_driver.sv
// Sequencer in front of the 128-bit Feistel cipher core. It buffers each operation's payload in
// full, replays command + payload to the core without gaps, and captures the core's burst output.
module cipher_stream_driver #(
  parameter int GUARD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_len,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic [7:0] core_ui,
  output logic [7:0] core_uio,
  input  logic [7:0] core_uo,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy
);

  typedef enum logic [1:0] {
    OP_KEY   = 2'b00,
    OP_START = 2'b01,
    OP_ENC   = 2'b10,
    OP_DEC   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_CMD,
    S_PAYLOAD,
    S_GUARD
  } state_e;

  localparam logic [1:0] GUARD_LAST = 2'(GUARD_CYCLES - 1);
  localparam logic [7:0] CODE_KEY   = 8'h01;
  localparam logic [7:0] CODE_START = 8'h0F;
  localparam logic [7:0] CODE_BURST = 8'h02;

  state_e     state_q;
  op_e        op_q;
  logic [4:0] cnt_q;
  logic [4:0] fill_q;
  logic [4:0] idx_q;
  logic [1:0] guard_q;
  logic [7:0] buf_q [16];

  logic       cmd_ready_q;
  logic       in_ready_q;
  logic       busy_q;
  logic       out_valid_q;
  logic       out_last_q;
  logic [7:0] out_data_q;
  logic [7:0] core_ui_q;
  logic       uio_mode_q;
  logic       uio_eos_q;

  logic       is_burst;
  logic [4:0] fill_d;
  logic [4:0] idx_d;
  logic [7:0] cmd_code;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    is_burst = 1'b0;
    fill_d   = fill_q + 5'd1;
    idx_d    = idx_q + 5'd1;
    cmd_code = CODE_KEY;
    if (op_q == OP_ENC || op_q == OP_DEC) begin
      is_burst = 1'b1;
      cmd_code = CODE_BURST;
    end else if (op_q == OP_START) begin
      cmd_code = CODE_START;
    end
  end

  // NOTE: the payload buffer is deliberately not reset; a slot is only read after FILL wrote it.
  always_ff @(posedge clk) begin
    if (state_q == S_FILL && in_valid) begin
      buf_q[fill_q[3:0]] <= in_data;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_KEY;
      cnt_q       <= 5'd0;
      fill_q      <= 5'd0;
      idx_q       <= 5'd0;
      guard_q     <= 2'd0;
      cmd_ready_q <= 1'b1;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= 8'h00;
      core_ui_q   <= 8'h00;
      uio_mode_q  <= 1'b0;
      uio_eos_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q        <= op_e'(cmd_op);
            cnt_q       <= cmd_op[1] ? {(cmd_len == 4'd0), cmd_len}
                                     : (cmd_op[0] ? 5'd1 : 5'd16);
            fill_q      <= 5'd0;
            state_q     <= S_FILL;
            cmd_ready_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        S_FILL: begin
          if (in_valid) begin
            fill_q <= fill_d;
            if (fill_d == cnt_q) begin
              state_q    <= S_CMD;
              in_ready_q <= 1'b0;
              core_ui_q  <= cmd_code;
              uio_mode_q <= (op_q == OP_DEC);
            end
          end
        end
        S_CMD: begin
          state_q   <= S_PAYLOAD;
          idx_q     <= 5'd0;
          core_ui_q <= buf_q[0];
          uio_eos_q <= is_burst && (cnt_q == 5'd1);
        end
        S_PAYLOAD: begin
          // core_uo reflects the byte on core_ui this cycle; capture it alongside that byte's index.
          if (is_burst) begin
            out_valid_q <= 1'b1;
            out_data_q  <= core_uo;
            out_last_q  <= (idx_d == cnt_q);
          end
          if (idx_d == cnt_q) begin
            state_q   <= S_GUARD;
            core_ui_q <= 8'h00;
            uio_eos_q <= 1'b0;
            guard_q   <= GUARD_LAST;
          end else begin
            idx_q     <= idx_d;
            core_ui_q <= buf_q[idx_d[3:0]];
            uio_eos_q <= is_burst && ((idx_d + 5'd1) == cnt_q);
          end
        end
        S_GUARD: begin
          if (guard_q == 2'd0) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            uio_mode_q  <= 1'b0;
          end else begin
            guard_q <= guard_q - 2'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign core_ui   = core_ui_q;
  assign core_uio  = {6'b000000, uio_eos_q, uio_mode_q};

endmodule

// File: tb/tb_cipher_stream_driver.sv
// Directed bench for cipher_stream_driver; a combinational XOR stand-in plays the cipher core,
// so encrypt followed by decrypt of its output recovers the original bytes.
module tb_cipher_stream_driver;

  localparam int         G  = 2;
  localparam logic [7:0] XK = 8'h5A;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_len = 4'h0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic [7:0] core_ui;
  logic [7:0] core_uio;
  logic [7:0] core_uo;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  always #5 clk = ~clk;

  assign core_uo = core_ui ^ XK;

  cipher_stream_driver #(.GUARD_CYCLES(G)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_ui(core_ui), .core_uio(core_uio), .core_uo(core_uo),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Per busy cycle: {cmd_ready, in_ready, out_valid, out_last, out_data, core_uio, core_ui}
  logic [27:0] trace[$];
  int          stray_ov = 0;

  always @(negedge clk) begin
    if (busy) trace.push_back({cmd_ready, in_ready, out_valid, out_last, out_data, core_uio, core_ui});
    else if (out_valid) stray_ov++;
  end

  logic [7:0] pay [16];
  logic [7:0] rx  [16];
  logic [7:0] orig[16];

  function automatic logic [31:0] reset_vec();
    return {13'd0, cmd_ready, in_ready, busy, out_valid, out_last, out_data, core_ui, core_uio};
  endfunction

  localparam logic [31:0] RESET_EXP = {13'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300 && busy; i++) @(negedge clk);
    check($sformatf("%s_idle", tag), 32'(busy), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input int n,
                        input bit throttle, input bit stray);
    int          fill_n;
    int          exp_len;
    int          p;
    logic [27:0] a;
    logic [27:0] e;
    logic        ov;
    trace.delete();
    stray_ov = 0;
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
    if (stray) begin
      in_valid = 1'b1;
      in_data  = 8'hEE;
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = op[1] ? 4'(n) : 4'hA;
    @(negedge clk);
    cmd_valid = stray;
    cmd_op    = 2'b00;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = pay[i];
      @(negedge clk);
      if (throttle && i < n - 1) begin
        in_valid = 1'b0;
        in_data  = 8'hEE;
        @(negedge clk);
      end
    end
    in_valid  = 1'b0;
    cmd_valid = 1'b0;
    wait_idle(tag);

    fill_n  = throttle ? 2 * n - 1 : n;
    exp_len = fill_n + 1 + n + G;
    check($sformatf("%s_len", tag), trace.size(), exp_len);
    for (int k = 0; k < exp_len && k < trace.size(); k++) begin
      a  = trace[k];
      e  = '0;
      ov = op[1] && k >= fill_n + 2 && k <= fill_n + n + 1;
      e[26] = (k < fill_n);
      if (k == fill_n) e[7:0] = op[1] ? 8'h02 : (op[0] ? 8'h0F : 8'h01);
      else if (k > fill_n && k <= fill_n + n) e[7:0] = pay[k - fill_n - 1];
      e[8] = (op == 2'b11) && k >= fill_n;
      e[9] = op[1] && k == fill_n + n;
      e[25] = ov;
      e[24] = ov && k == fill_n + n + 1;
      if (ov) begin
        p         = k - fill_n - 2;
        e[23:16]  = pay[p] ^ XK;
        rx[p]     = a[23:16];
      end else begin
        a[23:16] = 8'h00;
      end
      check($sformatf("%s[%0d]", tag, k), 32'(a), 32'(e));
    end
    check($sformatf("%s_idle_ov", tag), stray_ov, 0);
  endtask

  initial begin
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset", reset_vec(), RESET_EXP);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) pay[i] = 8'(i);
    run_op("key", 2'b00, 16, 1'b0, 1'b0);

    pay[0] = 8'h05;
    run_op("start", 2'b01, 1, 1'b0, 1'b0);

    pay[0] = 8'h12; pay[1] = 8'h34; pay[2] = 8'h02; pay[3] = 8'h0F;
    run_op("enc4", 2'b10, 4, 1'b0, 1'b1);

    for (int i = 0; i < 16; i++) pay[i] = 8'(i);
    run_op("rt_key", 2'b00, 16, 1'b0, 1'b0);
    pay[0] = 8'h00;
    run_op("rt_start", 2'b01, 1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      orig[i] = 8'(i * 17 + 3);
      pay[i]  = orig[i];
    end
    run_op("rt_enc", 2'b10, 16, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) pay[i] = rx[i];
    run_op("rt_dec", 2'b11, 16, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) check($sformatf("rt_recover[%0d]", i), 32'(rx[i]), 32'(orig[i]));

    for (int i = 0; i < 8; i++) pay[i] = 8'(8'h80 + i * 3);
    run_op("thr", 2'b10, 8, 1'b1, 1'b0);

    // Reset during the third payload cycle of a len=8 burst.
    for (int i = 0; i < 8; i++) pay[i] = 8'(8'hA0 + i);
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_len   = 4'd8;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = pay[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("rst_cmd", 32'(core_ui), 32'h02);
    repeat (3) @(negedge clk);
    check("rst_pl2", 32'(core_ui), 32'(pay[2]));
    stray_ov = 0;
    rst = 1'b1;
    #1;
    check("rst_async", reset_vec(), RESET_EXP);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_no_ov", stray_ov, 0);
    check("rst_idle", reset_vec(), RESET_EXP);

    pay[0] = 8'h0F;
    run_op("post_rst", 2'b01, 1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
